// File: rtl/bp_me_mem_cmd_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bp_me_mem_cmd_rr_arbiter_if
//   Bundle of the requester-side and memory-side handshake signals of the
//   round-robin mem_cmd arbiter.
//   Requester side (num_req_p lanes, flattened, lane r at [r*w +: w]):
//     req_header_i, req_data_i, req_v_i, req_last_i  -> arbiter
//     req_ready_and_o                                <- arbiter
//   Memory side:
//     mem_header_o, mem_data_o, mem_v_o, mem_last_o, mem_src_o <- arbiter
//     mem_ready_and_i                                          -> arbiter
//   modport master : the arbiter
//   modport slave  : the surrounding requesters / memory link
// ---------------------------------------------------------------------------
interface bp_me_mem_cmd_rr_arbiter_if #(
  parameter int num_req_p      = 4,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64,
  parameter int src_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
);
  logic [num_req_p*header_width_p-1:0] req_header_i;
  logic [num_req_p*data_width_p-1:0]   req_data_i;
  logic [num_req_p-1:0]                req_v_i;
  logic [num_req_p-1:0]                req_last_i;
  logic [num_req_p-1:0]                req_ready_and_o;

  logic [header_width_p-1:0]           mem_header_o;
  logic [data_width_p-1:0]             mem_data_o;
  logic                                mem_v_o;
  logic                                mem_last_o;
  logic                                mem_ready_and_i;
  logic [src_width_lp-1:0]             mem_src_o;

  modport master (
    input  req_header_i, req_data_i, req_v_i, req_last_i, mem_ready_and_i,
    output req_ready_and_o, mem_header_o, mem_data_o, mem_v_o, mem_last_o, mem_src_o
  );

  modport slave (
    output req_header_i, req_data_i, req_v_i, req_last_i, mem_ready_and_i,
    input  req_ready_and_o, mem_header_o, mem_data_o, mem_v_o, mem_last_o, mem_src_o
  );
endinterface

// File: rtl/bp_me_mem_cmd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bp_me_mem_cmd_rr_arbiter
//   Round-robin arbiter sharing one BedRock mem_cmd channel between
//   num_req_p requesters. Multi-beat messages stream through with zero
//   latency; once a requester's first beat is presented (stalled or
//   accepted non-last) the grant is locked to it until its last beat is
//   accepted.
//   Ports:
//     clk_i      clock
//     reset_n_i  synchronous active-low reset
//     bus        handshake bundle (master modport, see the interface file)
//     busy_o     a message is in flight (grant locked)
//     error_o    sticky: some message ran past max_beats_p beats
// ---------------------------------------------------------------------------
module bp_me_mem_cmd_rr_arbiter #(
  parameter int num_req_p      = 4,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64,
  parameter int max_beats_p    = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_me_mem_cmd_rr_arbiter_if.master  bus,
  output logic                        busy_o,
  output logic                        error_o
);

  localparam int src_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  // One extra code so the counter can saturate past max_beats_p-1.
  localparam int cnt_w_lp = $clog2(max_beats_p + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e                                   state_q, state_n;
  logic [src_w_lp-1:0]                      rr_ptr_q, rr_ptr_n;
  logic [src_w_lp-1:0]                      owner_q, owner_n;
  logic [cnt_w_lp-1:0]                      beat_cnt_q, beat_cnt_n;
  logic                                     error_q, error_n;

  logic [src_w_lp-1:0]                      pick_idx, grant;
  logic                                     pick_v, v_raw, xfer, last;
  logic [num_req_p-1:0]                     ready_vec;
  logic [num_req_p-1:0][header_width_p-1:0] hdr;
  logic [num_req_p-1:0][data_width_p-1:0]   dat;

  // Unflatten the per-requester buses.
  for (genvar r = 0; r < num_req_p; r++) begin : g_lane
    assign hdr[r] = bus.req_header_i[r*header_width_p +: header_width_p];
    assign dat[r] = bus.req_data_i[r*data_width_p +: data_width_p];
  end

  // Round-robin scan starting at rr_ptr, wrapping at num_req_p-1 -> 0.
  // Explicit wrap instead of power-of-2 masking so any num_req_p works.
  always_comb begin
    int idx;
    pick_v   = 1'b0;
    pick_idx = rr_ptr_q;
    idx      = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!pick_v && bus.req_v_i[src_w_lp'(idx)]) begin
        pick_v   = 1'b1;
        pick_idx = src_w_lp'(idx);
      end
    end
  end

  // In LOCK the owner keeps the channel even while it has no beat ready.
  assign grant = (state_q == LOCK) ? owner_q : pick_idx;
  assign v_raw = (state_q == LOCK) ? bus.req_v_i[owner_q] : pick_v;
  assign last  = bus.req_last_i[grant];
  assign xfer  = bus.mem_v_o & bus.mem_ready_and_i;

  always_comb begin
    ready_vec = '0;
    for (int r = 0; r < num_req_p; r++) begin
      ready_vec[r] = reset_n_i & bus.mem_ready_and_i & (grant == src_w_lp'(r));
    end
  end

  assign bus.req_ready_and_o = ready_vec;
  assign bus.mem_header_o    = hdr[grant];
  assign bus.mem_data_o      = dat[grant];
  assign bus.mem_last_o      = last;
  assign bus.mem_v_o         = reset_n_i & v_raw;
  assign bus.mem_src_o       = grant;
  assign busy_o              = reset_n_i & (state_q == LOCK);
  assign error_o             = error_q;

  always_comb begin
    state_n    = state_q;
    owner_n    = owner_q;
    rr_ptr_n   = rr_ptr_q;
    beat_cnt_n = beat_cnt_q;
    error_n    = error_q;

    unique case (state_q)
      // Lock on a stalled first beat or an accepted non-last beat; an
      // accepted single-beat message never leaves IDLE.
      IDLE: if (bus.mem_v_o && !(bus.mem_ready_and_i && last)) begin
        state_n = LOCK;
        owner_n = grant;
      end
      LOCK: if (xfer && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (xfer) begin
      if (last) begin
        beat_cnt_n = '0;
        rr_ptr_n   = (grant == src_w_lp'(num_req_p-1)) ? '0 : grant + src_w_lp'(1);
      end else begin
        if (beat_cnt_q == cnt_w_lp'(max_beats_p-1)) error_n = 1'b1;
        if (beat_cnt_q != cnt_w_lp'(max_beats_p))   beat_cnt_n = beat_cnt_q + cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      rr_ptr_q   <= rr_ptr_n;
      owner_q    <= owner_n;
      beat_cnt_q <= beat_cnt_n;
      error_q    <= error_n;
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_rr_arbiter.sv
module tb_bp_me_mem_cmd_rr_arbiter;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int HW = 128;
  localparam int DW = 64;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst3_n, busy, err, busy3, err3;
  int n_vec = 0;
  int n_err = 0;

  bp_me_mem_cmd_rr_arbiter_if #(.num_req_p(N),  .header_width_p(HW), .data_width_p(DW)) bus ();
  bp_me_mem_cmd_rr_arbiter_if #(.num_req_p(N3), .header_width_p(HW), .data_width_p(DW)) bus3 ();

  bp_me_mem_cmd_rr_arbiter #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus), .busy_o(busy), .error_o(err));

  bp_me_mem_cmd_rr_arbiter #(.num_req_p(N3), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)) dut3 (
    .clk_i(clk), .reset_n_i(rst3_n), .bus(bus3), .busy_o(busy3), .error_o(err3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all;
    bus.req_header_i = '0; bus.req_data_i = '0; bus.req_v_i = '0; bus.req_last_i = '0;
    bus.mem_ready_and_i = 1'b0;
    bus3.req_header_i = '0; bus3.req_data_i = '0; bus3.req_v_i = '0; bus3.req_last_i = '0;
    bus3.mem_ready_and_i = 1'b0;
  endtask

  task automatic drive(input int r, input bit v, input bit l, input logic [DW-1:0] d, input logic [HW-1:0] h);
    bus.req_v_i[r] = v;
    bus.req_last_i[r] = l;
    bus.req_data_i[r*DW +: DW] = d;
    bus.req_header_i[r*HW +: HW] = h;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst3_n = 1'b0;
    bus.req_v_i = '1; bus.req_last_i = '1; bus.mem_ready_and_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (bus.mem_v_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_v c%0d: got %b want 0", c, bus.mem_v_o); end
      n_vec++; if (bus.req_ready_and_o !== '0) begin n_err++; $display("FAIL reset_ready c%0d: got %b want 0000", c, bus.req_ready_and_o); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
      tick;
    end
    clear_all;
    rst_n = 1'b1; rst3_n = 1'b1;
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", err); end
    n_vec++; if (bus.mem_src_o !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", bus.mem_src_o); end
    n_vec++; if (bus.mem_v_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_v: got %b want 0", bus.mem_v_o); end
    tick;
  endtask

  task automatic test_fairness;
    for (int r = 0; r < N; r++) drive(r, 1'b1, 1'b1, DW'(r), HW'(r));
    bus.mem_ready_and_i = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (bus.mem_src_o !== 2'(k % N)) begin n_err++; $display("FAIL fair_src k%0d: got %0d want %0d", k, bus.mem_src_o, k % N); end
      n_vec++; if (bus.mem_v_o !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL fair_v_busy k%0d: got v=%b busy=%b want v=1 busy=0", k, bus.mem_v_o, busy); end
      tick;
    end
    clear_all;
    tick;
  endtask

  task automatic test_lock;
    bus.mem_ready_and_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, b == 3, DW'(64'hA000 + b), HW'(128'h1111));
      if (b >= 1) begin
        drive(0, 1'b1, 1'b1, DW'(64'hB000), HW'(128'h0));
        drive(2, 1'b1, 1'b1, DW'(64'hC000), HW'(128'h2));
      end
      #1;
      n_vec++; if (bus.mem_src_o !== 2'd1 || bus.mem_v_o !== 1'b1) begin n_err++; $display("FAIL lock_src b%0d: got src=%0d v=%b want src=1 v=1", b, bus.mem_src_o, bus.mem_v_o); end
      n_vec++; if (bus.mem_data_o !== DW'(64'hA000 + b) || bus.mem_last_o !== (b == 3)) begin n_err++; $display("FAIL lock_data b%0d: got %h/%b want %h/%b", b, bus.mem_data_o, bus.mem_last_o, 64'hA000 + b, b == 3); end
      n_vec++; if (busy !== (b > 0)) begin n_err++; $display("FAIL lock_busy b%0d: got %b want %b", b, busy, b > 0); end
      n_vec++; if (bus.req_ready_and_o !== 4'b0010) begin n_err++; $display("FAIL lock_ready b%0d: got %b want 0010", b, bus.req_ready_and_o); end
      tick;
    end
    bus.req_v_i[1] = 1'b0;
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd2 || busy !== 1'b0) begin n_err++; $display("FAIL lock_next2: got src=%0d busy=%b want src=2 busy=0", bus.mem_src_o, busy); end
    tick;
    bus.req_v_i[2] = 1'b0;
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd0) begin n_err++; $display("FAIL lock_next0: got %0d want 0", bus.mem_src_o); end
    tick;
    clear_all;
    tick;
  endtask

  task automatic test_stall;
    bus.mem_ready_and_i = 1'b0;
    drive(3, 1'b1, 1'b0, DW'(64'hD0), HW'(128'h3));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive(0, 1'b1, 1'b1, DW'(64'hE0), HW'(128'h0));
      #1;
      n_vec++; if (bus.mem_src_o !== 2'd3 || bus.mem_v_o !== 1'b1) begin n_err++; $display("FAIL stall_src c%0d: got src=%0d v=%b want src=3 v=1", c, bus.mem_src_o, bus.mem_v_o); end
      n_vec++; if (busy !== (c > 0) || bus.req_ready_and_o !== 4'b0000) begin n_err++; $display("FAIL stall_busy c%0d: got busy=%b rdy=%b want busy=%b rdy=0000", c, busy, bus.req_ready_and_o, c > 0); end
      tick;
    end
    bus.mem_ready_and_i = 1'b1;
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd3 || bus.req_ready_and_o !== 4'b1000) begin n_err++; $display("FAIL stall_rel: got src=%0d rdy=%b want src=3 rdy=1000", bus.mem_src_o, bus.req_ready_and_o); end
    tick;
    drive(3, 1'b1, 1'b1, DW'(64'hD1), HW'(128'h3));
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd3 || bus.mem_data_o !== DW'(64'hD1) || busy !== 1'b1) begin n_err++; $display("FAIL stall_last: got src=%0d data=%h busy=%b want 3/d1/1", bus.mem_src_o, bus.mem_data_o, busy); end
    tick;
    bus.req_v_i[3] = 1'b0;
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd0 || bus.mem_data_o !== DW'(64'hE0) || busy !== 1'b0) begin n_err++; $display("FAIL stall_after: got src=%0d data=%h busy=%b want 0/e0/0", bus.mem_src_o, bus.mem_data_o, busy); end
    tick;
    clear_all;
    tick;
  endtask

  task automatic test_wrap;
    bus3.mem_ready_and_i = 1'b1;
    bus3.req_v_i = 3'b100; bus3.req_last_i = 3'b111;
    #1;
    n_vec++; if (bus3.mem_src_o !== 2'd2) begin n_err++; $display("FAIL wrap_first: got %0d want 2", bus3.mem_src_o); end
    tick;
    bus3.req_v_i = 3'b011;
    #1;
    n_vec++; if (bus3.mem_src_o !== 2'd0) begin n_err++; $display("FAIL wrap_second: got %0d want 0", bus3.mem_src_o); end
    tick;
    n_vec++; if (bus3.mem_src_o !== 2'd1 || bus3.req_ready_and_o !== 3'b010) begin n_err++; $display("FAIL wrap_third: got src=%0d rdy=%b want 1/010", bus3.mem_src_o, bus3.req_ready_and_o); end
    tick;
    clear_all;
    tick;
  endtask

  // Random traffic against a message-level model: each requester owns a
  // queue-free "remaining beats" count; the model picks the owner by scanning
  // from the pointer with modulo arithmetic and holds it until its last beat.
  task automatic test_random;
    int rem [N];
    bit pres [N];
    logic [DW-1:0] dat [N];
    logic [HW-1:0] hdr [N];
    bit m_busy, m_err, ev, rdy, xfer, lst;
    int m_owner, m_ptr, m_cnt, g;
    logic [N-1:0] exp_rdy;
    rst_n = 1'b0; clear_all; tick; rst_n = 1'b1;
    m_busy = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int r = 0; r < N; r++) begin rem[r] = 0; pres[r] = 0; dat[r] = '0; hdr[r] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!pres[r]) begin
          if (rem[r] == 0 && $urandom_range(0, 3) == 0) begin
            rem[r] = $urandom_range(1, MB);
            hdr[r] = {$urandom, $urandom, $urandom, $urandom};
          end
          if (rem[r] != 0 && $urandom_range(0, 9) < 7) begin
            pres[r] = 1;
            dat[r] = {$urandom, $urandom};
          end
        end
        drive(r, pres[r], rem[r] == 1, dat[r], hdr[r]);
      end
      rdy = ($urandom_range(0, 3) != 0);
      bus.mem_ready_and_i = rdy;
      if (m_busy) begin
        g = m_owner; ev = pres[g];
      end else begin
        g = m_ptr; ev = 0;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (!ev && pres[j]) begin ev = 1; g = j; end
        end
      end
      exp_rdy = '0;
      if (rdy) exp_rdy[g] = 1'b1;
      #1;
      n_vec++; if (bus.mem_v_o !== ev) begin n_err++; $display("FAIL rnd_v cyc%0d: got %b want %b", cyc, bus.mem_v_o, ev); end
      n_vec++; if (bus.mem_src_o !== 2'(g)) begin n_err++; $display("FAIL rnd_src cyc%0d: got %0d want %0d", cyc, bus.mem_src_o, g); end
      if (ev) begin
        n_vec++; if (bus.mem_data_o !== dat[g] || bus.mem_header_o !== hdr[g] || bus.mem_last_o !== (rem[g] == 1)) begin
          n_err++; $display("FAIL rnd_payload cyc%0d: got data=%h last=%b want data=%h last=%b", cyc, bus.mem_data_o, bus.mem_last_o, dat[g], rem[g] == 1);
        end
      end
      if (ev || m_busy) begin
        n_vec++; if (bus.req_ready_and_o !== exp_rdy) begin n_err++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.req_ready_and_o, exp_rdy); end
      end
      n_vec++; if (busy !== m_busy || err !== m_err) begin n_err++; $display("FAIL rnd_busy_err cyc%0d: got %b/%b want %b/%b", cyc, busy, err, m_busy, m_err); end
      xfer = ev && rdy;
      if (xfer) begin
        lst = (rem[g] == 1);
        pres[g] = 0; rem[g]--;
        if (!lst && m_cnt == MB - 1) m_err = 1;
        m_cnt = lst ? 0 : m_cnt + 1;
        if (lst) begin m_ptr = (g + 1) % N; m_busy = 0; end
        else if (!m_busy) begin m_busy = 1; m_owner = g; end
      end else if (ev && !m_busy) begin
        m_busy = 1; m_owner = g;
      end
      tick;
    end
    clear_all;
    tick;
  endtask

  task automatic test_error;
    rst_n = 1'b0; clear_all; tick; rst_n = 1'b1;
    bus.mem_ready_and_i = 1'b1;
    for (int b = 0; b < 9; b++) begin
      drive(0, 1'b1, b == 8, DW'(b), HW'(128'h5));
      #1;
      n_vec++; if (err !== (b >= 8)) begin n_err++; $display("FAIL err_rise b%0d: got %b want %b", b, err, b >= 8); end
      n_vec++; if (bus.mem_src_o !== 2'd0 || bus.mem_v_o !== 1'b1) begin n_err++; $display("FAIL err_src b%0d: got %0d/%b want 0/1", b, bus.mem_src_o, bus.mem_v_o); end
      tick;
    end
    bus.req_v_i[0] = 1'b0;
    drive(2, 1'b1, 1'b1, DW'(64'h77), HW'(128'h2));
    #1;
    n_vec++; if (bus.mem_src_o !== 2'd2 || bus.mem_data_o !== DW'(64'h77) || err !== 1'b1) begin n_err++; $display("FAIL err_traffic: got src=%0d data=%h err=%b want 2/77/1", bus.mem_src_o, bus.mem_data_o, err); end
    tick;
    clear_all;
    #1;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL err_sticky: got err=%b busy=%b want 1/0", err, busy); end
    tick;
  endtask

  initial begin
    clear_all;
    rst_n = 1'b0; rst3_n = 1'b0;
    test_reset;
    test_fairness;
    test_lock;
    test_stall;
    test_wrap;
    test_random;
    test_error;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
